// File: rtl/vrf_rd_arb.sv
// VRF read-port arbiter: maps requesters onto BANK_RPORT read slots per bank,
// starved ports first then round-robin, with one registered output stage.
module vrf_rd_arb #(
    parameter int RPORT_NUM  = 5,
    parameter int BANK_NUM   = 4,
    parameter int BANK_RPORT = 2,
    parameter int VADDR_W    = 6,
    parameter int RS_IDX_W   = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [RPORT_NUM-1:0]                            req_vld,
    input  logic [RPORT_NUM-1:0][VADDR_W-1:0]               req_vaddr,
    input  logic [RPORT_NUM-1:0][RS_IDX_W-1:0]              req_rs_idx,
    input  logic [RPORT_NUM-1:0][1:0]                       req_rs_field_idx,
    output logic [RPORT_NUM-1:0]                            req_rdy,
    input  logic                                            stall,
    input  logic                                            flush,
    output logic [RPORT_NUM-1:0]                            out_vld,
    output logic [RPORT_NUM-1:0][VADDR_W-1:0]               out_vaddr,
    output logic [RPORT_NUM-1:0][RS_IDX_W-1:0]              out_rs_idx,
    output logic [RPORT_NUM-1:0][1:0]                       out_rs_field_idx,
    output logic [BANK_NUM-1:0][BANK_RPORT-1:0]             out_bank_ren,
    output logic [BANK_NUM-1:0][BANK_RPORT-1:0][VADDR_W-3:0] out_bank_row,
    output logic [BANK_NUM-1:0][BANK_RPORT-1:0][2:0]        out_bank_src
);

    localparam int PTR_W = $clog2(RPORT_NUM);
    localparam int CNT_W = 2;
    localparam int ROW_W = VADDR_W - 2;
    localparam int SRC_W = 3;

    function automatic logic [1:0] bank_of(input logic [VADDR_W-1:0] a);
        return {a[VADDR_W-1], a[0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(STARVE_MAX)) ? c : c + CNT_W'(1);
    endfunction

    logic [PTR_W-1:0]                             r_rr_ptr;
    logic [RPORT_NUM-1:0][CNT_W-1:0]              r_wait;

    logic [RPORT_NUM-1:0]                         w_starved;
    logic [RPORT_NUM-1:0][PTR_W-1:0]              w_rank;
    logic [RPORT_NUM-1:0][1:0]                    w_bank;
    logic [RPORT_NUM-1:0]                         w_rdy_raw;
    logic [BANK_NUM-1:0][BANK_RPORT-1:0]          w_slot_ren;
    logic [BANK_NUM-1:0][BANK_RPORT-1:0][ROW_W-1:0] w_slot_row;
    logic [BANK_NUM-1:0][BANK_RPORT-1:0][SRC_W-1:0] w_slot_src;
    logic                                         w_conflict;

    logic [RPORT_NUM-1:0]                         r_vld_p1;
    logic [RPORT_NUM-1:0][VADDR_W-1:0]            r_vaddr_p1;
    logic [RPORT_NUM-1:0][RS_IDX_W-1:0]           r_rs_idx_p1;
    logic [RPORT_NUM-1:0][1:0]                    r_field_p1;
    logic [BANK_NUM-1:0][BANK_RPORT-1:0]          r_ren_p1;
    logic [BANK_NUM-1:0][BANK_RPORT-1:0][ROW_W-1:0] r_row_p1;
    logic [BANK_NUM-1:0][BANK_RPORT-1:0][SRC_W-1:0] r_src_p1;

    // rank = round-robin distance of each port from the pointer
    always_comb begin
        int d;
        d         = 0;
        w_starved = '0;
        w_rank    = '0;
        w_bank    = '0;
        for (int q = 0; q < RPORT_NUM; q++) begin
            w_starved[q] = (r_wait[q] == CNT_W'(STARVE_MAX));
            w_bank[q]    = bank_of(req_vaddr[q]);
            d            = q - int'(r_rr_ptr);
            if (d < 0) d = d + RPORT_NUM;
            w_rank[q]    = PTR_W'(d);
        end
    end

    // ---- p0: per-bank slot allocation (pass 0 = starved by index, pass 1 = round-robin)
    always_comb begin
        int                   cnt;
        int                   nreq;
        logic [RPORT_NUM-1:0] cand;
        logic                 elig;
        cnt        = 0;
        nreq       = 0;
        cand       = '0;
        elig       = 1'b0;
        w_rdy_raw  = '0;
        w_slot_ren = '0;
        w_slot_row = '0;
        w_slot_src = '0;
        w_conflict = 1'b0;
        for (int b = 0; b < BANK_NUM; b++) begin
            cnt  = 0;
            nreq = 0;
            for (int q = 0; q < RPORT_NUM; q++) begin
                cand[q] = req_vld[q] && (int'(w_bank[q]) == b);
                if (cand[q]) nreq = nreq + 1;
            end
            for (int pass = 0; pass < 2; pass++) begin
                for (int k = 0; k < RPORT_NUM; k++) begin
                    for (int q = 0; q < RPORT_NUM; q++) begin
                        if (pass == 0) elig = w_starved[q] && (q == k);
                        else           elig = !w_starved[q] && (int'(w_rank[q]) == k);
                        if (cand[q] && elig && (cnt < BANK_RPORT)) begin
                            w_rdy_raw[q] = 1'b1;
                            for (int s = 0; s < BANK_RPORT; s++) begin
                                if (s == cnt) begin
                                    w_slot_ren[b][s] = 1'b1;
                                    w_slot_row[b][s] = req_vaddr[q][ROW_W:1];
                                    w_slot_src[b][s] = SRC_W'(q);
                                end
                            end
                            cnt = cnt + 1;
                        end
                    end
                end
            end
            if (nreq > BANK_RPORT) w_conflict = 1'b1;
        end
    end

    assign req_rdy = (rst || stall || flush) ? '0 : w_rdy_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_wait   <= '0;
        end else begin
            for (int q = 0; q < RPORT_NUM; q++) begin
                if (flush)                        r_wait[q] <= '0;
                else if (req_vld[q] && !req_rdy[q]) r_wait[q] <= sat_inc(r_wait[q]);
                else                              r_wait[q] <= '0;
            end
            if (w_conflict && !stall && !flush)
                r_rr_ptr <= (r_rr_ptr == PTR_W'(RPORT_NUM - 1)) ? '0 : r_rr_ptr + PTR_W'(1);
        end
    end

    // ---- p1: registered grants; flush clears valids, stall freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1    <= '0;
            r_vaddr_p1  <= '0;
            r_rs_idx_p1 <= '0;
            r_field_p1  <= '0;
            r_ren_p1    <= '0;
            r_row_p1    <= '0;
            r_src_p1    <= '0;
        end else if (flush) begin
            r_vld_p1 <= '0;
            r_ren_p1 <= '0;
        end else if (!stall) begin
            r_vld_p1 <= req_rdy;
            r_ren_p1 <= w_slot_ren;
            for (int q = 0; q < RPORT_NUM; q++) begin
                if (req_rdy[q]) begin
                    r_vaddr_p1[q]  <= req_vaddr[q];
                    r_rs_idx_p1[q] <= req_rs_idx[q];
                    r_field_p1[q]  <= req_rs_field_idx[q];
                end
            end
            for (int b = 0; b < BANK_NUM; b++) begin
                for (int s = 0; s < BANK_RPORT; s++) begin
                    if (w_slot_ren[b][s]) begin
                        r_row_p1[b][s] <= w_slot_row[b][s];
                        r_src_p1[b][s] <= w_slot_src[b][s];
                    end
                end
            end
        end
    end

    assign out_vld          = r_vld_p1;
    assign out_vaddr        = r_vaddr_p1;
    assign out_rs_idx       = r_rs_idx_p1;
    assign out_rs_field_idx = r_field_p1;
    assign out_bank_ren     = r_ren_p1;
    assign out_bank_row     = r_row_p1;
    assign out_bank_src     = r_src_p1;

endmodule
